// File: rtl/pll_nco_enable_gen_if.sv
// Configuration bus for pll_nco_enable_gen: channel retune writes, reject flag and realign request.
interface pll_nco_enable_gen_if #(
    parameter int ACC_W = 32
);
    logic             cfg_wr;
    logic [3:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_incr;
    logic [ACC_W-1:0] cfg_phase;
    logic             cfg_err;
    logic             sync_req;

    modport master (
        output cfg_wr, cfg_ch, cfg_incr, cfg_phase, sync_req,
        input  cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_incr, cfg_phase, sync_req,
        output cfg_err
    );
endinterface

// File: rtl/pll_nco_enable_gen.sv
// Multi-channel NCO clock-enable / square-wave generator with lock indicator.
// Optional feature macro: PLL_NCO_PHASE_ALIGN_EN (stored phase offsets + sync_req realignment).
module pll_nco_enable_gen #(
    parameter int              NUM_CH      = 2,
    parameter int              ACC_W       = 32,
    parameter int              LOCK_CYCLES = 1024,
    parameter longint unsigned INIT_INCR   = 0
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_nco_enable_gen_if.slave   cfg,
    output logic [NUM_CH-1:0]     en_out,
    output logic [NUM_CH-1:0]     outclk,
    output logic                  locked
);
    localparam int               CNT_W      = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [ACC_W-1:0] INIT_INCR_V = ACC_W'(INIT_INCR);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    lock_state_t      state;
    logic [CNT_W-1:0] lock_cnt;
    logic [ACC_W-1:0] acc     [NUM_CH];
    logic [ACC_W-1:0] incr    [NUM_CH];
    logic [ACC_W:0]   sum_ext [NUM_CH];
    logic             wr_ok;
    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range channel indices are rejected rather than aliased onto a real channel.
    always_comb begin
        wr_ok  = cfg.cfg_wr && ({1'b0, cfg.cfg_ch} < 5'(NUM_CH));
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i]  = wr_ok && (cfg.cfg_ch == 4'(i));
            sum_ext[i] = {1'b0, acc[i]} + {1'b0, incr[i]};
        end
    end

`ifdef PLL_NCO_PHASE_ALIGN_EN
    logic [ACC_W-1:0] phase [NUM_CH];

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) phase[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sel[i]) phase[i] <= cfg.cfg_phase;
            end
        end
    end
`else
    logic unused_sync_req;
    assign unused_sync_req = cfg.sync_req;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]  <= '0;
                incr[i] <= INIT_INCR_V;
            end
            en_out <= '0;
            outclk <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sel[i]) begin
                    acc[i]    <= cfg.cfg_phase;
                    incr[i]   <= cfg.cfg_incr;
                    en_out[i] <= 1'b0;
                    outclk[i] <= cfg.cfg_phase[ACC_W-1];
`ifdef PLL_NCO_PHASE_ALIGN_EN
                end else if (cfg.sync_req) begin
                    acc[i]    <= phase[i];
                    en_out[i] <= 1'b0;
                    outclk[i] <= phase[i][ACC_W-1];
`endif
                end else begin
                    // The carry out of the add is the wrap event that becomes the strobe.
                    acc[i]    <= sum_ext[i][ACC_W-1:0];
                    en_out[i] <= sum_ext[i][ACC_W];
                    outclk[i] <= sum_ext[i][ACC_W-1];
                end
            end
        end
    end

    // Lock timer restarts on every accepted write and saturates once locked.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            lock_cnt <= '0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= cfg.cfg_wr && !wr_ok;
            if (wr_ok) begin
                state    <= UNLOCKED;
                locked   <= 1'b0;
                lock_cnt <= '0;
            end else begin
                case (state)
                    UNLOCKED: begin
                        lock_cnt <= lock_cnt + 1'b1;
                        if (lock_cnt == LOCK_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        locked <= 1'b1;
                    end
                    default: begin
                        state  <= UNLOCKED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_nco_enable_gen.sv
// Self-checking bench for pll_nco_enable_gen: directed scenarios plus randomized traffic vs. a cycle model.
module tb_pll_nco_enable_gen;
    localparam int NUM_CH = 2;
    localparam int ACC_W  = 8;
    localparam int LOCK_N = 16;

    logic              refclk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] outclk;
    logic              locked;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: plain integers, phase in [0,256)
    int m_acc   [NUM_CH];
    int m_incr  [NUM_CH];
    int m_phase [NUM_CH];
    bit [NUM_CH-1:0] m_en;
    bit [NUM_CH-1:0] m_oc;
    bit m_err;
    int since_restart;

    pll_nco_enable_gen_if #(.ACC_W(ACC_W)) bus ();

    pll_nco_enable_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_N),
        .INIT_INCR   (0)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .cfg    (bus),
        .en_out (en_out),
        .outclk (outclk),
        .locked (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ok;
        bit align;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_acc[i] = 0; m_incr[i] = 0; m_phase[i] = 0;
            end
            m_en = '0; m_oc = '0; m_err = 1'b0; since_restart = 0;
            return;
        end
        ok    = bus.cfg_wr && (int'(bus.cfg_ch) < NUM_CH);
        m_err = bus.cfg_wr && !ok;
`ifdef PLL_NCO_PHASE_ALIGN_EN
        align = bus.sync_req;
`else
        align = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (ok && int'(bus.cfg_ch) == i) begin
                m_acc[i]   = int'(bus.cfg_phase);
                m_incr[i]  = int'(bus.cfg_incr);
                m_phase[i] = int'(bus.cfg_phase);
                m_en[i]    = 1'b0;
            end else if (align) begin
                m_acc[i] = m_phase[i];
                m_en[i]  = 1'b0;
            end else begin
                m_en[i]  = (m_acc[i] + m_incr[i]) >= 256;
                m_acc[i] = (m_acc[i] + m_incr[i]) % 256;
            end
            m_oc[i] = m_acc[i] >= 128;
        end
        if (ok) since_restart = 0;
        else if (since_restart < LOCK_N) since_restart++;
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        #1;
        check("en_out", 8'(en_out), 8'(m_en));
        check("outclk", 8'(outclk), 8'(m_oc));
        check("locked", 8'(locked), 8'(since_restart >= LOCK_N));
        check("cfg_err", 8'(bus.cfg_err), 8'(m_err));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_write(input int ch, input int inc, input int ph);
        bus.cfg_wr    = 1'b1;
        bus.cfg_ch    = 4'(ch);
        bus.cfg_incr  = 8'(inc);
        bus.cfg_phase = 8'(ph);
        tick();
        bus.cfg_wr = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_incr = '0;
        bus.cfg_phase = '0; bus.sync_req = 1'b0;

        // Reset state
        ticks(2);
        check("rst_en_out", 8'(en_out), 8'h00);
        check("rst_outclk", 8'(outclk), 8'h00);
        check("rst_locked", 8'(locked), 8'h00);
        rst = 1'b0;

        // Idle: locked rises exactly on the 16th edge after release
        ticks(LOCK_N - 1);
        check("lock_edge15", 8'(locked), 8'h00);
        tick();
        check("lock_edge16", 8'(locked), 8'h01);
        ticks(4);

        // ch0 divide-by-4
        do_write(0, 64, 0);
        check("wr_unlock", 8'(locked), 8'h00);
        ticks(4);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin tick(); cnt += int'(en_out[0]); end
        check("ch0_rate", 8'(cnt), 8'd2);

        // ch1 3/8 rate
        do_write(1, 96, 0);
        ticks(3);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin tick(); cnt += int'(en_out[1]); end
        check("ch1_rate", 8'(cnt), 8'd3);
        ticks(LOCK_N);

        // Rejected write while locked
        check("pre_bad_locked", 8'(locked), 8'h01);
        do_write(5, 200, 77);
        check("bad_err", 8'(bus.cfg_err), 8'h01);
        check("bad_locked", 8'(locked), 8'h01);
        tick();
        check("bad_err_gone", 8'(bus.cfg_err), 8'h00);

        // Two writes 10 cycles apart restart the lock count from the second
        do_write(0, 32, 0);
        ticks(9);
        do_write(1, 128, 64);
        ticks(LOCK_N - 1);
        check("relock_15", 8'(locked), 8'h00);
        tick();
        check("relock_16", 8'(locked), 8'h01);

`ifdef PLL_NCO_PHASE_ALIGN_EN
        // Anti-phase realignment
        do_write(0, 64, 0);
        do_write(1, 64, 128);
        ticks(3);
        bus.sync_req = 1'b1; tick(); bus.sync_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("antiphase", 8'(outclk[1]), 8'(~outclk[0]));
        end
`endif

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rst          = ($urandom_range(0, 63) == 0);
            bus.cfg_wr   = ($urandom_range(0, 7) == 0);
            bus.cfg_ch   = 4'($urandom_range(0, 3));
            bus.cfg_incr = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            bus.cfg_phase = 8'($urandom);
            bus.sync_req = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 1'b0; bus.cfg_wr = 1'b0; bus.sync_req = 1'b0;

        // Reset mid-count returns everything to reset values next edge
        do_write(0, 255, 10);
        ticks(5);
        rst = 1'b1;
        tick();
        check("midrst_en_out", 8'(en_out), 8'h00);
        check("midrst_outclk", 8'(outclk), 8'h00);
        check("midrst_locked", 8'(locked), 8'h00);
        rst = 1'b0;
        ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
